// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line-format codes and helpers
// used by both rx_control and tx_control.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int SAMPLING_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [1:0] STOP_TWO     = 2'b10;
  localparam logic [1:0] STOP_TWO_ALT = 2'b11;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

  function automatic logic is_two_stop(input logic [1:0] code);
    return (code == STOP_TWO) || (code == STOP_TWO_ALT);
  endfunction

  // data_par is the XOR of all received data bits, pbit the received parity bit.
  function automatic logic parity_error(input logic [1:0] mode, input logic data_par,
                                        input logic pbit);
    case (mode)
      PAR_ODD:  return (data_par ^ pbit) != 1'b1;
      PAR_EVEN: return (data_par ^ pbit) != 1'b0;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rx_sampler.sv
// Serial-line front end: 2-flop synchronizer and a 3-sample majority voter
// centred on the middle of each bit period.
module rx_sampler
  import uart_pkg::*;
#(
  parameter int SAMPLING = SAMPLING_DEF,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bclk_i,
  input  logic             rxd_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             line_o,
  output logic             vote_o
);

  localparam logic [CNT_W-1:0] CNT_A = CNT_W'(SAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_B = CNT_W'(SAMPLING / 2);

  logic [1:0] sync_q;
  logic [1:0] samp_q;

  // Synchronize the asynchronous line; idle level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
    end
  end

  // Capture the first two of the three vote samples; the third is the live line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q <= 2'b11;
    end else if (bclk_i) begin
      if (cnt_i == CNT_A) begin
        samp_q[0] <= sync_q[1];
      end else if (cnt_i == CNT_B) begin
        samp_q[1] <= sync_q[1];
      end
    end
  end

  assign line_o = sync_q[1];
  assign vote_o = maj3(samp_q[0], samp_q[1], sync_q[1]);

endmodule

// File: rtl/rx_control.sv
// UART receiver: oversampled start detection, data/parity/stop framing and
// registered frame results with a one-cycle data_valid strobe.
module rx_control
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SAMPLING   = SAMPLING_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic [1:0]            parity,
  input  logic [1:0]            stop,
  input  logic                  s_data_in,
  output logic [DATA_WIDTH-1:0] p_data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(SAMPLING);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SAMPLING - 1);
  localparam logic [CW-1:0] CNT_MID_HI = CW'(SAMPLING / 2 + 1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH);

  uart_state_e           state_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  stop_idx_q;
  logic                  armed_q;
  logic [1:0]            par_mode_q;
  logic                  two_stop_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  perr_f_q;
  logic                  ferr_f_q;
  logic [DATA_WIDTH-1:0] p_data_out_q;
  logic                  data_valid_q;
  logic                  parity_err_q;
  logic                  frame_err_q;
  logic                  busy_q;

  logic                  line_s;
  logic                  vote_s;
  logic [CW-1:0]         cnt_d;
  logic                  stop_fail_d;

  rx_sampler #(
    .SAMPLING (SAMPLING),
    .CNT_W    (CW)
  ) u_sampler (
    .clk    (clk),
    .reset  (reset),
    .bclk_i (bclk),
    .rxd_i  (s_data_in),
    .cnt_i  (cnt_q),
    .line_o (line_s),
    .vote_o (vote_s)
  );

  assign cnt_d       = (cnt_q == CNT_LAST) ? CNT_ZERO : cnt_q + CNT_ONE;
  assign stop_fail_d = ferr_f_q | ~vote_s;

  // Frame FSM: every counter and state step is gated by the bclk tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      bit_cnt_q    <= '0;
      stop_idx_q   <= 1'b0;
      armed_q      <= 1'b1;
      par_mode_q   <= PAR_NONE;
      two_stop_q   <= 1'b0;
      shift_q      <= '0;
      perr_f_q     <= 1'b0;
      ferr_f_q     <= 1'b0;
      p_data_out_q <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (bclk) begin
        case (state_q)
          ST_IDLE: begin
            cnt_q <= CNT_ZERO;
            // After a framing error the line must be seen high before re-arming.
            if (!armed_q) begin
              if (line_s) begin
                armed_q <= 1'b1;
              end
            end else if (!line_s) begin
              state_q    <= ST_START;
              busy_q     <= 1'b1;
              bit_cnt_q  <= '0;
              stop_idx_q <= 1'b0;
              perr_f_q   <= 1'b0;
              ferr_f_q   <= 1'b0;
              par_mode_q <= parity;
              two_stop_q <= is_two_stop(stop);
            end
          end
          ST_START: begin
            cnt_q <= cnt_d;
            if (cnt_q == CNT_MID_HI && vote_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            cnt_q <= cnt_d;
            if (cnt_q == CNT_MID_HI) begin
              shift_q   <= {vote_s, shift_q[DATA_WIDTH-1:1]};
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
            end else if (cnt_q == CNT_LAST && bit_cnt_q == BIT_LAST) begin
              state_q <= has_parity(par_mode_q) ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: begin
            cnt_q <= cnt_d;
            if (cnt_q == CNT_MID_HI) begin
              perr_f_q <= parity_error(par_mode_q, ^shift_q, vote_s);
            end else if (cnt_q == CNT_LAST) begin
              state_q <= ST_STOP;
            end
          end
          ST_STOP: begin
            cnt_q <= cnt_d;
            if (cnt_q == CNT_MID_HI) begin
              // The last stop bit ends the frame immediately, without waiting out the bit.
              if (stop_idx_q == two_stop_q) begin
                state_q      <= ST_IDLE;
                busy_q       <= 1'b0;
                cnt_q        <= CNT_ZERO;
                data_valid_q <= 1'b1;
                p_data_out_q <= shift_q;
                parity_err_q <= perr_f_q;
                frame_err_q  <= stop_fail_d;
                armed_q      <= ~stop_fail_d;
              end else begin
                ferr_f_q <= stop_fail_d;
              end
            end else if (cnt_q == CNT_LAST) begin
              stop_idx_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign p_data_out = p_data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: doc/rx_control.md
RX_CONTROL -- requirements
Module: rx_control

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have parameter SAMPLING, default 16, bclk ticks per bit period; even and >= 8.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-005 bclk  input  1  oversample tick enable, one clk cycle wide, SAMPLING x baud rate.
REQ-006 parity  input  2  parity mode: 00 none, 01 odd, 10 even, 11 none.
REQ-007 stop  input  2  stop-bit count: 00/01 one stop bit, 10/11 two stop bits.
REQ-008 s_data_in  input  1  asynchronous serial line; idle high, LSB first.
REQ-009 p_data_out  output  DATA_WIDTH  last received word.
REQ-010 data_valid  output  1  one-clk pulse when a frame completes.
REQ-011 parity_err  output  1  parity mismatch for the last frame.
REQ-012 frame_err  output  1  stop bit sampled low for the last frame.
REQ-013 busy  output  1  high from start detection until return to IDLE.

Function
REQ-014 s_data_in SHALL pass through a 2-flop synchronizer on clk before any use.
REQ-015 All counters and the FSM SHALL advance only in clk cycles where bclk=1; no logic clocked by bclk.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE->START on a bclk tick with synced line 0 and the armed flag set; sample_cnt cleared to 0; parity and stop latched for the frame.
REQ-018 sample_cnt SHALL count 0..SAMPLING-1 per bit and wrap to 0; bit value = majority of samples at SAMPLING/2-1, SAMPLING/2, SAMPLING/2+1.
REQ-019 START: majority 1 at count SAMPLING/2+1 -> IDLE (false start) with no outputs changed; otherwise -> DATA at count SAMPLING-1.
REQ-020 DATA: shift in bits LSB first; after DATA_WIDTH bits, at count SAMPLING-1 -> PARITY if parity is 01/10, else -> STOP.
REQ-021 PARITY: at count SAMPLING-1 -> STOP; error if (^data ^ bit) != 1 for odd or != 0 for even.
REQ-022 STOP: each stop bit evaluated at count SAMPLING/2+1; any low stop bit sets the frame error.
REQ-023 After the final stop bit is evaluated, the FSM SHALL go to IDLE on the same tick without waiting for count SAMPLING-1.
REQ-024 data_valid SHALL pulse in the clk cycle after that tick; p_data_out, parity_err, frame_err update in the same cycle and hold until the next data_valid.
REQ-025 On frame_err the armed flag SHALL clear; it sets again on the first bclk tick with synced line 1; this blocks restart during a break.
REQ-026 busy=1 in START, DATA, PARITY, STOP; 0 in IDLE.
REQ-027 With bclk held 0 the block SHALL freeze all state; parity/stop changes mid-frame SHALL be ignored.

Reset
REQ-028 On reset: state IDLE, counters 0, armed 1, p_data_out 0, data_valid 0, parity_err 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no data_valid; reception resumes at the next valid start bit after release.

Structure
REQ-030 Package uart_pkg SHALL hold the state encoding, parity codes (NONE/ODD/EVEN), stop codes, and DATA_WIDTH/SAMPLING defaults, shared with tx_control.
REQ-031 Sub-module rx_sampler SHALL contain the 2-flop synchronizer and the 3-sample majority voter; the FSM, counters and shift register stay in rx_control.

Verification (DATA_WIDTH=8, SAMPLING=16, bclk every 4 clk)
REQ-032 0xA5, parity 00, stop 00 -> one data_valid pulse, p_data_out=0xA5, parity_err=0, frame_err=0, busy low after.
REQ-033 0x3C, parity 10, parity bit 0 -> parity_err=0; repeat with parity bit 1 -> parity_err=1, p_data_out=0x3C.
REQ-034 Line low for 4 bclk ticks, then high -> no data_valid, busy pulses then returns 0, next 0x55 frame received correctly.
REQ-035 0x81, stop 10, second stop bit driven 0 -> frame_err=1, p_data_out=0x81; held-low line -> no new frame until the line returns high.
REQ-036 reset asserted during data bit 4 of 0xF0 -> all outputs 0, no data_valid; following 0x5A frame -> p_data_out=0x5A.
REQ-037 Single-tick glitch (1 sample flipped) at mid-bit of each data bit of 0x96 -> majority vote gives p_data_out=0x96, no errors.
